clock_time_core: RTL

//  Timekeeping and time-set controller for the digital clock, directly upstream of the display stage.

---
 rtl/clock_pkg.sv | 40 ++++
 rtl/btn_edge_sync.sv | 26 ++
 rtl/clock_time_core.sv | 120 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants, state type and digit-increment helper for the clock core
package clock_pkg;

  localparam logic [2:0] POS_SEC_LO = 3'd0;
  localparam logic [2:0] POS_SEC_HI = 3'd1;
  localparam logic [2:0] POS_MIN_LO = 3'd2;
  localparam logic [2:0] POS_MIN_HI = 3'd3;
  localparam logic [2:0] POS_HR_LO  = 3'd4;
  localparam logic [2:0] POS_HR_HI  = 3'd5;

  localparam logic [5:0] MAX_HR = 6'd23;
  localparam logic [5:0] MAX_MS = 6'd59;

  typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;

  // Bumps one decimal digit of a 0..59 / 0..23 field; no carry into the other digit.
  function automatic logic [5:0] digit_inc(input logic [5:0] value, input logic [2:0] p);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [3:0] lim;
    logic [7:0] r;
    hi  = 4'(value / 6'd10);
    lo  = 4'(value % 6'd10);
    lim = (hi == 4'd2) ? 4'd3 : 4'd9;
    case (p)
      POS_SEC_LO, POS_MIN_LO: lo = (lo >= 4'd9) ? 4'd0 : lo + 4'd1;
      POS_SEC_HI, POS_MIN_HI: hi = (hi >= 4'd5) ? 4'd0 : hi + 4'd1;
      POS_HR_LO:              lo = (lo >= lim) ? 4'd0 : lo + 4'd1;
      POS_HR_HI: begin
        hi = (hi >= 4'd2) ? 4'd0 : hi + 4'd1;
        // 20..23 is the only legal decade starting with 2
        if (hi == 4'd2 && lo > 4'd3) lo = 4'd0;
      end
      default: ;
    endcase
    r = {4'd0, hi} * 8'd10 + {4'd0, lo};
    return r[5:0];
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - button synchroniser with single-cycle rising-edge detect
module btn_edge_sync #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign rise = sync_q[SYNC_DEPTH-1] & ~prev_q;

endmodule

// File: rtl/clock_time_core.sv
// rtl/clock_time_core.sv - 1 s divider, 24 h time count and RUN/SET button-driven time setting
module clock_time_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SYNC_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_shift,
  input  logic       btn_inc,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [2:0] pos,
  output logic       set_mod,
  output logic       sec_pulse
);

  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

  logic mode_rise, shift_rise, inc_rise;

  btn_edge_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_mode (
    .clk(clk), .rst_n(rst_n), .din(btn_mode), .rise(mode_rise)
  );
  btn_edge_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_shift (
    .clk(clk), .rst_n(rst_n), .din(btn_shift), .rise(shift_rise)
  );
  btn_edge_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_inc (
    .clk(clk), .rst_n(rst_n), .din(btn_inc), .rise(inc_rise)
  );

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic [2:0]       pos_q, pos_d;
  logic [5:0]       sec_inc, min_inc, hr_inc;
  logic             tick;

  assign tick = (div_q == DIV_MAX);

  // Full hh:mm:ss carry chain resolved in one cycle
  always_comb begin
    sec_inc = sec_q + 6'd1;
    min_inc = min_q;
    hr_inc  = hr_q;
    if (sec_q == MAX_MS) begin
      sec_inc = '0;
      if (min_q == MAX_MS) begin
        min_inc = '0;
        hr_inc  = (hr_q == MAX_HR) ? '0 : hr_q + 6'd1;
      end else begin
        min_inc = min_q + 6'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    pos_d   = pos_q;
    case (state_q)
      ST_RUN: begin
        if (tick) begin
          sec_d = sec_inc;
          min_d = min_inc;
          hr_d  = hr_inc;
        end
        if (mode_rise) state_d = ST_SET;
      end
      ST_SET: begin
        if (mode_rise) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else begin
          // inc acts on the current pos even when shift moves it this cycle
          if (inc_rise) begin
            if (pos_q <= POS_SEC_HI)      sec_d = digit_inc(sec_q, pos_q);
            else if (pos_q <= POS_MIN_HI) min_d = digit_inc(min_q, pos_q);
            else                          hr_d  = digit_inc(hr_q, pos_q);
          end
          if (shift_rise) pos_d = (pos_q == POS_HR_HI) ? POS_SEC_LO : pos_q + 3'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      div_q   <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      pos_q   <= POS_SEC_LO;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pos_q   <= pos_d;
    end
  end

  assign hours     = hr_q;
  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign pos       = pos_q;
  assign set_mod   = (state_q == ST_SET);
  assign sec_pulse = tick;

endmodule
